// File: rtl/fft_shift_back_stage_pkg.sv
// Shared FFT definitions used by the shift-back output stage.
//   FFT_DATA_SAMPLE     packed {imag, re}, both two's complement components
//   fft_cap_entry_t     one captured sample plus its end-of-frame tag
//   fft_stage_state_e   IDLE / RUN / DRAIN
//   clamp_log2()        maps an illegal frame size onto the largest legal one
package fft_pkg;

    localparam int unsigned DATA_WIDTH  = 64;
    localparam int unsigned COMP_WIDTH  = DATA_WIDTH / 2;
    localparam int unsigned SHIFT_WIDTH = 5;
    localparam int unsigned MAX_LOG2    = 12;

    typedef struct packed {
        logic [COMP_WIDTH-1:0] imag;
        logic [COMP_WIDTH-1:0] re;
    } FFT_DATA_SAMPLE;

    typedef struct packed {
        logic           last;
        FFT_DATA_SAMPLE data;
    } fft_cap_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fft_stage_state_e;

    // A size of 0 or above the largest supported FFT falls back to the largest one.
    function automatic logic [3:0] clamp_log2(input logic [3:0] p);
        if (p == 4'd0 || p > 4'(MAX_LOG2)) begin
            return 4'(MAX_LOG2);
        end
        return p;
    endfunction

endpackage

// File: rtl/fft_shift_back_stage_if.sv
// Data path between the bit-reversal FIFO, the shift-back stage and dma_wrap.
//   in_valid / in_data / in_ready         sample stream into the stage
//   out_valid / out_data / out_last /
//   out_ready                             scaled sample stream toward dma_wrap
// Modports: slave = the stage itself, master = the surrounding environment.
interface fft_shift_back_stage_if;
    import fft_pkg::*;

    logic           in_valid;
    FFT_DATA_SAMPLE in_data;
    logic           in_ready;
    logic           out_valid;
    FFT_DATA_SAMPLE out_data;
    logic           out_last;
    logic           out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/fft_shift_back_stage_sat_shift.sv
// Combinational saturating arithmetic left shift of one signed component.
//   x    in   W   two's complement input
//   s    in   SW  shift amount
//   y    out  W   x <<< s, clipped to the most positive/negative value on overflow
//   sat  out  1   overflow occurred (never for x == 0)
module fft_sat_shift #(
    parameter int unsigned W  = 32,
    parameter int unsigned SW = 5
) (
    input  logic [W-1:0]  x,
    input  logic [SW-1:0] s,
    output logic [W-1:0]  y,
    output logic          sat
);

    logic [2*W-1:0] wide;
    logic [W:0]     top;
    logic           big_shift;

    always_comb begin
        wide = {{W{x[W-1]}}, x} << s;
        // Bits above the result's sign, plus the sign itself, must all agree;
        // otherwise a shifted-out bit differed from the kept sign.
        top       = wide[2*W-1:W-1];
        big_shift = (32'(s) >= W) && (x != '0);
        sat       = big_shift || !((&top) || !(|top));
        if (sat) begin
            y = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            y = wide[W-1:0];
        end
    end

endmodule

// File: rtl/fft_shift_back_stage.sv
// Output post-processing stage: undoes block-floating-point scaling by shifting
// each complex sample left by the frame's shift_back with saturation, counts
// samples per frame, tags the last one and pulses frame_done after it leaves.
//   clk, rst      clock, asynchronous active-high reset
//   start         pulse; latches point_log2/shift_back and begins a frame (IDLE only)
//   abort         pulse; flushes the pipeline and returns to IDLE
//   point_log2    frame size N = 1 << point_log2 (clamped to MAX_LOG2 if illegal)
//   shift_back    left-shift amount for the frame
//   bus           sample streams in and out (slave modport)
//   busy          state != IDLE
//   frame_done    one-cycle pulse after the last sample's output handshake
//   sat_flag      sticky saturation indicator, cleared on start
module fft_shift_back_stage
    import fft_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [3:0]             point_log2,
    input  logic [SHIFT_WIDTH-1:0] shift_back,
    fft_shift_back_stage_if.slave  bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   sat_flag
);

    fft_stage_state_e       state_q, state_d;
    logic [3:0]             plog2_q;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic [MAX_LOG2-1:0]    in_cnt_q;
    logic [MAX_LOG2-1:0]    last_idx;
    fft_cap_entry_t         cap_q [2];
    logic [1:0]             cap_cnt_q, cap_cnt_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q;
    FFT_DATA_SAMPLE         out_data_q;
    logic                   out_last_q;
    logic                   frame_done_q;
    logic                   sat_flag_q;

    logic                   start_ok;
    logic                   in_fire;
    logic                   in_last;
    logic                   out_fire;
    logic                   out_load;
    fft_cap_entry_t         in_entry;
    logic [COMP_WIDTH-1:0]  re_y, im_y;
    logic                   sat_re, sat_im;

    assign start_ok = start && !abort && (state_q == IDLE);
    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;
    assign out_load = (cap_cnt_q != 2'd0) && (!out_valid_q || bus.out_ready);
    assign last_idx = ~({MAX_LOG2{1'b1}} << plog2_q);
    assign in_last  = (in_cnt_q == last_idx);

    always_comb begin
        in_entry      = '0;
        in_entry.last = in_last;
        in_entry.data = bus.in_data;
    end

    fft_sat_shift #(.W(COMP_WIDTH), .SW(SHIFT_WIDTH)) u_sat_re (
        .x   (cap_q[0].data.re),
        .s   (shift_q),
        .y   (re_y),
        .sat (sat_re)
    );

    fft_sat_shift #(.W(COMP_WIDTH), .SW(SHIFT_WIDTH)) u_sat_im (
        .x   (cap_q[0].data.imag),
        .s   (shift_q),
        .y   (im_y),
        .sat (sat_im)
    );

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (in_fire && in_last) state_d = DRAIN;
                DRAIN:   if (out_fire && out_last_q) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // in_ready is registered: it is asserted for the next cycle only if the
    // 2-entry capture buffer will still have a free slot after this edge,
    // so an input accepted while the output stalls always has somewhere to go.
    always_comb begin
        cap_cnt_d = cap_cnt_q;
        case ({in_fire, out_load})
            2'b10:   cap_cnt_d = cap_cnt_q + 2'd1;
            2'b01:   cap_cnt_d = cap_cnt_q - 2'd1;
            default: cap_cnt_d = cap_cnt_q;
        endcase
        in_ready_d = (state_d == RUN) && (cap_cnt_d != 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            plog2_q      <= '0;
            shift_q      <= '0;
            in_cnt_q     <= '0;
            cap_q[0]     <= '0;
            cap_q[1]     <= '0;
            cap_cnt_q    <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            sat_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            frame_done_q <= !abort && (state_q == DRAIN) && out_fire && out_last_q;

            if (start_ok) begin
                plog2_q    <= clamp_log2(point_log2);
                shift_q    <= shift_back;
                in_cnt_q   <= '0;
                sat_flag_q <= 1'b0;
            end

            if (abort) begin
                cap_cnt_q   <= '0;
                in_cnt_q    <= '0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                cap_cnt_q <= cap_cnt_d;

                if (in_fire) begin
                    in_cnt_q <= in_last ? '0 : in_cnt_q + MAX_LOG2'(1);
                end

                case ({in_fire, out_load})
                    2'b10: cap_q[cap_cnt_q[0]] <= in_entry;
                    2'b01: cap_q[0] <= cap_q[1];
                    2'b11: begin
                        if (cap_cnt_q == 2'd1) begin
                            cap_q[0] <= in_entry;
                        end else begin
                            cap_q[0] <= cap_q[1];
                            cap_q[1] <= in_entry;
                        end
                    end
                    default: ;
                endcase

                if (out_load) begin
                    out_valid_q     <= 1'b1;
                    out_data_q.re   <= re_y;
                    out_data_q.imag <= im_y;
                    out_last_q      <= cap_q[0].last;
                    if (sat_re || sat_im) begin
                        sat_flag_q <= 1'b1;
                    end
                end else if (out_fire) begin
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q != IDLE);
    assign frame_done    = frame_done_q;
    assign sat_flag      = sat_flag_q;

endmodule

// File: tb/tb_fft_shift_back_stage.sv
// Scoreboard bench for fft_shift_back_stage: expected scaled samples are queued
// when an input handshake is seen and compared when the output handshake occurs.
module tb_fft_shift_back_stage;

    typedef struct {
        logic [63:0] data;
        logic        last;
        longint      cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [3:0]  point_log2;
    logic [4:0]  shift_back;
    logic        busy;
    logic        frame_done;
    logic        sat_flag;

    fft_shift_back_stage_if bus ();

    fft_shift_back_stage dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .point_log2 (point_log2),
        .shift_back (shift_back),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .sat_flag   (sat_flag)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    exp_t        sb[$];
    longint      cyc = 0;
    int unsigned cur_n = 8;
    int unsigned cur_shift = 0;
    int unsigned in_idx = 0;
    logic        in_drain = 1'b0;
    logic        exp_done = 1'b0;
    logic        held = 1'b0;
    logic [63:0] held_data = '0;
    logic        held_last = 1'b0;
    logic        lat_check = 1'b0;
    int unsigned frames_done = 0;
    int unsigned out_count = 0;
    int unsigned ready_mode = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(1));
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat_model(input logic [31:0] x, input int unsigned s);
        longint v;
        v = longint'($signed(x)) * (longint'(1) << s);
        if (v > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        if (v < -64'sh8000_0000) return 32'h8000_0000;
        return v[31:0];
    endfunction

    function automatic int unsigned frame_len(input logic [3:0] p);
        if (p == 4'd0 || p > 4'd12) return 4096;
        return 1 << p;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check_eq("frame_done", 64'(frame_done), 64'(exp_done));
            exp_done = 1'b0;
            if (in_drain) check_eq("in_ready_drain", 64'(bus.in_ready), 64'd0);
            if (bus.in_valid && bus.in_ready) begin
                e.data = {sat_model(bus.in_data[63:32], cur_shift),
                          sat_model(bus.in_data[31:0], cur_shift)};
                e.last = (in_idx == cur_n - 1);
                e.cyc  = cyc;
                sb.push_back(e);
                if (e.last) begin
                    in_idx   = 0;
                    in_drain = 1'b1;
                end else begin
                    in_idx++;
                end
            end
            if (held) begin
                check_eq("stall_valid", 64'(bus.out_valid), 64'd1);
                check_eq("stall_data", bus.out_data, held_data);
                check_eq("stall_last", 64'(bus.out_last), 64'(held_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                held = 1'b0;
                if (sb.size() == 0) begin
                    check_eq("out_extra", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    out_count++;
                    check_eq("out_data", bus.out_data, e.data);
                    check_eq("out_last", 64'(bus.out_last), 64'(e.last));
                    if (lat_check) check_eq("latency", 64'(cyc - e.cyc), 64'd2);
                    if (e.last) begin
                        exp_done = 1'b1;
                        in_drain = 1'b0;
                        frames_done++;
                    end
                end
            end else if (bus.out_valid) begin
                held      = 1'b1;
                held_data = bus.out_data;
                held_last = bus.out_last;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic flush_model();
        sb.delete();
        in_idx   = 0;
        in_drain = 1'b0;
        held     = 1'b0;
        exp_done = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        check_eq({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check_eq({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
        check_eq({tag, "_out_data"}, bus.out_data, 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check_eq({tag, "_sat_flag"}, 64'(sat_flag), 64'd0);
    endtask

    task automatic start_frame(input logic [3:0] p, input logic [4:0] s);
        int unsigned t = 0;
        while (busy && t < 1000) begin
            @(posedge clk);
            t++;
        end
        check_eq("idle_before_start", 64'(busy), 64'd0);
        #1;
        point_log2 = p;
        shift_back = s;
        start      = 1'b1;
        cur_n      = frame_len(p);
        cur_shift  = s;
        in_idx     = 0;
        out_count  = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input int unsigned idle_pct);
        int unsigned waited = 0;
        while (idle_pct != 0 && $urandom_range(99) < idle_pct) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.in_ready && waited < 500);
        check_eq("in_accept", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_frame(input int unsigned exp_count);
        int unsigned t = 0;
        int unsigned base = frames_done;
        while (frames_done == base && t < 10000) begin
            @(negedge clk);
            t++;
        end
        check_eq("frame_end_seen", 64'(frames_done - base), 64'd1);
        check_eq("out_count", 64'(out_count), 64'(exp_count));
        @(negedge clk);
        @(negedge clk);
        check_eq("busy_after_frame", 64'(busy), 64'd0);
        check_eq("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d frames expected completion", frames_done);
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        point_log2   = 4'd0;
        shift_back   = 5'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #2;
        check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk);

        // 1: pass-through, full rate, latency and last/frame_done timing
        ready_mode = 1;
        lat_check  = 1'b1;
        start_frame(4'd3, 5'd0);
        for (int i = 0; i < 8; i++) send({$urandom, $urandom}, 0);
        wait_frame(8);
        check_eq("t1_sat_flag", 64'(sat_flag), 64'd0);
        lat_check = 1'b0;

        // 2: non-saturating shift on both signs
        start_frame(4'd1, 5'd4);
        send(64'hFFFF_FFF0_0000_0123, 0);
        send(64'h0000_0001_FFFF_FFFF, 0);
        wait_frame(2);
        check_eq("t2_sat_flag", 64'(sat_flag), 64'd0);

        // 3: positive and negative saturation, zero never saturates
        start_frame(4'd1, 5'd8);
        send(64'h8000_0001_0100_0000, 0);
        send(64'h0000_0000_0000_0000, 0);
        wait_frame(2);
        check_eq("t3_sat_flag", 64'(sat_flag), 64'd1);
        repeat (3) @(posedge clk);
        check_eq("t3_sat_sticky", 64'(sat_flag), 64'd1);

        // 4: random valid/ready back-pressure
        ready_mode = 2;
        start_frame(4'd4, 5'd3);
        check_eq("t4_sat_cleared", 64'(sat_flag), 64'd0);
        for (int i = 0; i < 16; i++) send({$urandom, $urandom}, 50);
        wait_frame(16);

        // 5: abort mid-frame, then a clean frame
        ready_mode = 1;
        start_frame(4'd3, 5'd2);
        for (int i = 0; i < 5; i++) send({$urandom, $urandom}, 0);
        abort        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        abort = 1'b0;
        flush_model();
        check_eq("t5_busy_after_abort", 64'(busy), 64'd0);
        check_eq("t5_in_ready_after_abort", 64'(bus.in_ready), 64'd0);
        check_eq("t5_out_valid_after_abort", 64'(bus.out_valid), 64'd0);
        repeat (4) @(posedge clk);
        start_frame(4'd3, 5'd2);
        for (int i = 0; i < 8; i++) send({$urandom, $urandom}, 0);
        wait_frame(8);

        // illegal size clamps to 4096 points; large shift saturates nonzero values
        start_frame(4'd0, 5'd31);
        for (int i = 0; i < 4096; i++) send((i % 4 == 0) ? 64'd0 : {$urandom, $urandom}, 0);
        wait_frame(4096);

        // 6: asynchronous reset while a sample is stalled at the output
        ready_mode = 0;
        start_frame(4'd4, 5'd8);
        send(64'h7FFF_FFFF_0000_0001, 0);
        send(64'h0000_0002_0000_0003, 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("t6_out_valid_stalled", 64'(bus.out_valid), 64'd1);
        check_eq("t6_sat_before_rst", 64'(sat_flag), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("t6_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush_model();
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t6_in_ready_no_start", 64'(bus.in_ready), 64'd0);
            check_eq("t6_busy_no_start", 64'(busy), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        ready_mode   = 1;
        start_frame(4'd2, 5'd1);
        for (int i = 0; i < 4; i++) send({$urandom, $urandom}, 0);
        wait_frame(4);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
